line_fill_requester: RTL and testbench
======================================

Name: line_fill_requester

Overview:
Client-side cache-line fill engine that sits directly upstream of the two-client bus arbiter and occupies one arbiter client port (reqN/respN signal set).
- Accepts a line-fill request from a cache miss handler and issues one read request on the arbiter port.
- Collects the 8 x 64-bit response beats, acknowledging each beat.
- Presents the assembled 512-bit line to the cache with a valid/ready handshake.

Parameters:
ADDR_W, 64, address width of fill request and bus_req
DATA_W, 64, width of one response beat
BEATS, 8, beats per line; line width = BEATS*DATA_W
TAG_W, 13, width of reqtag/resptag
READ_TAG, 13'h1100, tag value driven with every read request

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
fill_valid  in  1  cache requests a line fill
fill_addr  in  ADDR_W  miss address (any byte in the line)
fill_ready  out  1  block can accept a fill (high only in IDLE)
line_valid  out  1  assembled line available
line_ready  in  1  cache consumes the line
line_data  out  BEATS*DATA_W  line; beat k at bits [k*DATA_W +: DATA_W]
line_addr  out  ADDR_W  line-aligned address of the returned line
tag_err  out  1  sticky: a beat with wrong resptag was seen
bus_req  out  ADDR_W  request address to arbiter port
bus_reqcyc  out  1  request valid
bus_reqtag  out  TAG_W  request tag
bus_reqack  in  1  arbiter accepted request
bus_resp  in  DATA_W  response beat data
bus_respcyc  in  1  response beat valid
bus_resptag  in  TAG_W  response beat tag
bus_respack  out  1  beat accepted

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous, active-high.
- Reset (synchronous): state=IDLE, beat counter=0, line_data=0, line_addr=0, tag_err=0; bus_reqcyc, bus_respack, line_valid=0; bus_req=0, bus_reqtag=0.
- Reset mid-operation aborts the fill. Outstanding beats arriving after reset are not acked.
- FSM states: IDLE, REQ, COLLECT, DONE.
- IDLE:
  - fill_ready=1.
  - fill_valid=1: latch line-aligned address (fill_addr with low 6 bits cleared), go to REQ next cycle.
- REQ:
  - bus_reqcyc=1, bus_req=latched address, bus_reqtag=READ_TAG.
  - Hold all three stable until bus_reqack=1 is sampled at a clk edge, then go to COLLECT.
  - No timeout.
- COLLECT:
  - bus_respack = bus_respcyc (combinational, same cycle). Block is always ready.
  - Beat with respcyc=1 and resptag==READ_TAG: store bus_resp into slot[beat]; beat++ (3-bit counter).
  - Beat with mismatching tag: acked and discarded; tag_err set (sticky until reset); counter unchanged.
  - Accepting the beat with counter==BEATS-1: counter wraps to 0, go to DONE next cycle.
- DONE:
  - line_valid=1; line_data and line_addr stable.
  - On line_ready=1: go to IDLE next cycle; line_valid drops.
  - line_data retains its value until overwritten by the next fill.
- Per-state signal rules:
  - bus_respack=0 in IDLE, REQ and DONE. Any respcyc in those states is ignored, with no ack and no capture.
  - bus_reqack=1 outside REQ is ignored.
  - bus_reqack and bus_respcyc high together in REQ: the request is accepted but the beat is not (respack=0). The arbiter must re-present the beat.
- Throughput: at most one outstanding fill. Minimum latency from fill accept to line_valid = 1 (REQ) + reqack wait + 8 beat cycles + 1.

Decomposition:
- Shared package bus_pkg:
  - constants DATA_W, ADDR_W, TAG_W, BEATS, READ_TAG, WRITE_TAG;
  - typedef fill_state_t enum {IDLE, REQ, COLLECT, DONE};
  - typedef line_t (logic [BEATS*DATA_W-1:0]).
- The arbiter imports the same package.
- One sub-module is natural: beat_collector (counter + line shift/slot register + tag check), instanced under the FSM.

Test Plan:
- Basic fill: fill_addr=0x1238, reqack after 2 cycles, 8 beats 0x0..0x7 back-to-back with tag 0x1100 -> bus_req=0x1200 held 3 cycles; respack high 8 cycles; line_valid with line_addr=0x1200, beat k = k; tag_err=0.
- Gapped beats: respcyc deasserted for 3 cycles between beats 3 and 4 -> respack follows respcyc exactly; line complete after 8th valid beat only.
- Tag mismatch: beat 5 sent with tag 0x0800, followed by a correct beat 5 -> mismatched beat acked and discarded; tag_err=1; line still holds correct 8 words.
- Backpressure: line_ready held low 5 cycles in DONE -> line_valid and line_data stable; fill_ready=0; new fill_valid not accepted until one cycle after line_ready.
- Reqack/respcyc overlap: reqack and respcyc high together in REQ -> respack=0 that cycle; beat captured the following cycle when re-presented.
- Reset mid-fill: reset after beat 3 -> next cycle IDLE, outputs at reset values; a subsequent fill returns a clean line.

Source files
------------

// File: rtl/line_fill_requester_pkg.sv
// Shared bus constants and types for the arbiter and its clients.
// Line fill engine widths, tags and FSM encoding live here.
package bus_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int BEATS  = 8;
  localparam int TAG_W  = 13;
  localparam int LINE_W = BEATS * DATA_W;
  localparam int CNT_W  = $clog2(BEATS);
  localparam int OFF_W  = $clog2(LINE_W / 8);

  localparam logic [TAG_W-1:0] READ_TAG  = 13'h1100;
  localparam logic [TAG_W-1:0] WRITE_TAG = 13'h0800;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    COLLECT,
    DONE
  } fill_state_t;

  typedef logic [LINE_W-1:0] line_t;

  function automatic logic [ADDR_W-1:0] line_align(
    input logic [ADDR_W-1:0] a
  );
    return {a[ADDR_W-1:OFF_W], OFF_W'(0)};
  endfunction

endpackage

// File: rtl/line_fill_requester_if.sv
// One arbiter client port: request channel plus response beat channel.
// master = requesting client, slave = arbiter side.
interface line_fill_requester_if;
  import bus_pkg::*;

  logic [ADDR_W-1:0] req;
  logic              reqcyc;
  logic [TAG_W-1:0]  reqtag;
  logic              reqack;
  logic [DATA_W-1:0] resp;
  logic              respcyc;
  logic [TAG_W-1:0]  resptag;
  logic              respack;

  modport master (
    output req,
    output reqcyc,
    output reqtag,
    input  reqack,
    input  resp,
    input  respcyc,
    input  resptag,
    output respack
  );

  modport slave (
    input  req,
    input  reqcyc,
    input  reqtag,
    output reqack,
    output resp,
    output respcyc,
    output resptag,
    input  respack
  );

endinterface

// File: rtl/line_fill_requester_beat_collector.sv
// Beat counter, per-slot line register and response tag check.
// Wrong-tag beats are dropped without advancing the counter.
module beat_collector
  import bus_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              respcyc,
  input  logic [TAG_W-1:0]  resptag,
  input  logic [DATA_W-1:0] resp,
  output line_t             line,
  output logic              last,
  output logic              tag_err
);

  logic [CNT_W-1:0] cnt;
  logic             hit;
  logic             miss;

  assign hit  = en & respcyc & (resptag == READ_TAG);
  assign miss = en & respcyc & (resptag != READ_TAG);
  assign last = hit & (cnt == CNT_W'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      line    <= '0;
      tag_err <= 1'b0;
    end else begin
      if (hit) begin
        line[cnt*DATA_W +: DATA_W] <= resp;
        cnt <= cnt + 1'b1;
      end
      if (miss) begin
        tag_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/line_fill_requester.sv
// Cache line fill engine on one arbiter client port:
// one read request, eight beats collected, line handed to the cache.
module line_fill_requester
  import bus_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                fill_valid,
  input  logic [ADDR_W-1:0]   fill_addr,
  output logic                fill_ready,
  output logic                line_valid,
  input  logic                line_ready,
  output line_t               line_data,
  output logic [ADDR_W-1:0]   line_addr,
  output logic                tag_err,
  line_fill_requester_if.master bus
);

  fill_state_t       state;
  logic [ADDR_W-1:0] addr_q;
  logic              last;
  logic              collecting;

  assign collecting  = (state == COLLECT);
  assign fill_ready  = (state == IDLE);
  assign line_valid  = (state == DONE);
  assign line_addr   = addr_q;

  assign bus.reqcyc  = (state == REQ);
  assign bus.req     = bus.reqcyc ? addr_q : '0;
  assign bus.reqtag  = bus.reqcyc ? READ_TAG : '0;
  // No backpressure on beats: every beat seen while collecting is acked.
  assign bus.respack = collecting & bus.respcyc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      addr_q <= '0;
    end else begin
      unique case (1'b1)
        state == IDLE: begin
          if (fill_valid) begin
            addr_q <= line_align(fill_addr);
            state  <= REQ;
          end
        end
        state == REQ: begin
          if (bus.reqack) state <= COLLECT;
        end
        state == COLLECT: begin
          if (last) state <= DONE;
        end
        state == DONE: begin
          if (line_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  beat_collector u_collect (
    .clk     (clk),
    .reset   (reset),
    .en      (collecting),
    .respcyc (bus.respcyc),
    .resptag (bus.resptag),
    .resp    (bus.resp),
    .line    (line_data),
    .last    (last),
    .tag_err (tag_err)
  );

endmodule

// File: tb/tb_line_fill_requester.sv
// Scoreboard bench for line_fill_requester: expected lines queued at
// fill accept, compared when line_valid rises.
module tb_line_fill_requester;
  import bus_pkg::*;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    line_t             data;
  } exp_t;

  logic              clk;
  logic              reset;
  logic              fill_valid;
  logic [ADDR_W-1:0] fill_addr;
  logic              fill_ready;
  logic              line_valid;
  logic              line_ready;
  line_t             line_data;
  logic [ADDR_W-1:0] line_addr;
  logic              tag_err;

  line_fill_requester_if bus ();

  line_fill_requester dut (
    .clk        (clk),
    .reset      (reset),
    .fill_valid (fill_valid),
    .fill_addr  (fill_addr),
    .fill_ready (fill_ready),
    .line_valid (line_valid),
    .line_ready (line_ready),
    .line_data  (line_data),
    .line_addr  (line_addr),
    .tag_err    (tag_err),
    .bus        (bus.master)
  );

  exp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                       input logic [LINE_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic line_t mk_line(input logic [DATA_W-1:0] base);
    line_t l;
    for (int k = 0; k < BEATS; k++) l[k*DATA_W +: DATA_W] = base + DATA_W'(k);
    return l;
  endfunction

  task automatic start_fill(input logic [ADDR_W-1:0] a, input line_t l);
    exp_t e;
    int   n;
    n = 0;
    while (!fill_ready && n < 20) begin step(); n++; end
    check("fill_ready", fill_ready, 1);
    fill_valid = 1'b1;
    fill_addr  = a;
    step();
    fill_valid = 1'b0;
    e.addr = {a[ADDR_W-1:6], 6'b0};
    e.data = l;
    q.push_back(e);
  endtask

  task automatic req_phase(input int waits, input logic [ADDR_W-1:0] ea);
    for (int i = 0; i < waits; i++) begin
      check("reqcyc_wait", bus.reqcyc, 1);
      check("req_addr", bus.req, ea);
      check("req_tag", bus.reqtag, READ_TAG);
      step();
    end
    bus.reqack = 1'b1;
    #1;
    check("reqcyc_ack", bus.reqcyc, 1);
    check("req_addr_ack", bus.req, ea);
    step();
    bus.reqack = 1'b0;
    check("reqcyc_drop", bus.reqcyc, 0);
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] d,
                           input logic [TAG_W-1:0] t);
    bus.respcyc = 1'b1;
    bus.resp    = d;
    bus.resptag = t;
    #1;
    check("respack_beat", bus.respack, 1);
    step();
    bus.respcyc = 1'b0;
  endtask

  task automatic send_beats(input logic [DATA_W-1:0] base,
                            input int first, input int cnt);
    for (int k = first; k < first + cnt; k++)
      send_beat(base + DATA_W'(k), READ_TAG);
  endtask

  task automatic gap(input int n);
    bus.respcyc = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      check("respack_gap", bus.respack, 0);
      check("no_line_gap", line_valid, 0);
      step();
    end
  endtask

  task automatic finish_line(input int hold, input logic hold_fill);
    exp_t e;
    int   n;
    n = 0;
    while (!line_valid && n < 40) begin step(); n++; end
    check("line_valid", line_valid, 1);
    if (q.size() == 0) begin
      check("sb_empty", 0, 1);
    end else begin
      e = q.pop_front();
      check("line_data", line_data, e.data);
      check("line_addr", line_addr, e.addr);
      fill_valid = hold_fill;
      for (int i = 0; i < hold; i++) begin
        line_ready = 1'b0;
        step();
        check("bp_valid", line_valid, 1);
        check("bp_data", line_data, e.data);
        check("bp_fill_ready", fill_ready, 0);
        check("bp_reqcyc", bus.reqcyc, 0);
      end
    end
    line_ready = 1'b1;
    step();
    line_ready = 1'b0;
    check("line_drop", line_valid, 0);
    check("fill_ready_back", fill_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    line_t l;
    exp_t  e;
    reset       = 1'b1;
    fill_valid  = 1'b0;
    fill_addr   = '0;
    line_ready  = 1'b0;
    bus.reqack  = 1'b0;
    bus.resp    = '0;
    bus.respcyc = 1'b0;
    bus.resptag = '0;
    step();
    step();
    check("rst_fill_ready", fill_ready, 1);
    check("rst_line_valid", line_valid, 0);
    check("rst_reqcyc", bus.reqcyc, 0);
    check("rst_req", bus.req, 0);
    check("rst_reqtag", bus.reqtag, 0);
    check("rst_respack", bus.respack, 0);
    check("rst_tag_err", tag_err, 0);
    check("rst_line_data", line_data, 0);
    check("rst_line_addr", line_addr, 0);
    reset = 1'b0;

    // stray handshakes while idle
    bus.respcyc = 1'b1;
    bus.reqack  = 1'b1;
    #1;
    check("idle_respack", bus.respack, 0);
    step();
    check("idle_reqcyc", bus.reqcyc, 0);
    bus.respcyc = 1'b0;
    bus.reqack  = 1'b0;

    // basic fill
    start_fill(64'h1238, mk_line(0));
    req_phase(2, 64'h1200);
    send_beats(0, 0, 8);
    finish_line(0, 1'b0);
    check("basic_tag_err", tag_err, 0);

    // gapped beats
    start_fill(64'h4_0077, mk_line(64'h100));
    req_phase(0, 64'h4_0040);
    send_beats(64'h100, 0, 4);
    gap(3);
    send_beats(64'h100, 4, 4);
    finish_line(0, 1'b0);

    // tag mismatch on beat 5
    start_fill(64'hABCD_EF3F, mk_line(64'h200));
    req_phase(1, 64'hABCD_EF00);
    send_beats(64'h200, 0, 5);
    send_beat(64'hDEAD, 13'h0800);
    check("mis_no_done", line_valid, 0);
    send_beats(64'h200, 5, 3);
    check("mis_tag_err", tag_err, 1);
    finish_line(0, 1'b0);
    check("mis_tag_sticky", tag_err, 1);

    // backpressure, with the next fill waiting
    start_fill(64'h8000, mk_line(64'h300));
    req_phase(0, 64'h8000);
    send_beats(64'h300, 0, 8);
    fill_addr = 64'h9_0010;
    finish_line(5, 1'b1);
    check("next_not_yet", bus.reqcyc, 0);
    step();
    fill_valid = 1'b0;
    check("next_accepted", bus.reqcyc, 1);
    check("next_fill_ready", fill_ready, 0);
    e.addr = 64'h9_0000;
    e.data = mk_line(64'h400);
    q.push_back(e);

    // reqack and respcyc together in REQ
    check("ovl_req", bus.req, 64'h9_0000);
    bus.reqack  = 1'b1;
    bus.respcyc = 1'b1;
    bus.resp    = 64'h400;
    bus.resptag = READ_TAG;
    #1;
    check("ovl_respack", bus.respack, 0);
    step();
    bus.reqack = 1'b0;
    send_beats(64'h400, 0, 8);
    finish_line(0, 1'b0);

    // reset after beat 3 with a beat still arriving
    l = mk_line(64'h500);
    start_fill(64'h7_7777, l);
    req_phase(1, 64'h7_7740);
    send_beats(64'h500, 0, 4);
    reset       = 1'b1;
    bus.respcyc = 1'b1;
    bus.resp    = 64'h504;
    bus.resptag = READ_TAG;
    step();
    reset = 1'b0;
    void'(q.pop_back());
    #1;
    check("mr_respack", bus.respack, 0);
    check("mr_fill_ready", fill_ready, 1);
    check("mr_reqcyc", bus.reqcyc, 0);
    check("mr_line_valid", line_valid, 0);
    check("mr_line_data", line_data, 0);
    check("mr_line_addr", line_addr, 0);
    check("mr_tag_err", tag_err, 0);
    step();
    bus.respcyc = 1'b0;
    check("mr_still_idle", bus.reqcyc, 0);

    start_fill(64'h6_0008, mk_line(64'h600));
    req_phase(1, 64'h6_0000);
    send_beats(64'h600, 0, 8);
    finish_line(0, 1'b0);
    check("clean_tag_err", tag_err, 0);
    check("sb_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
